// File: rtl/shift_unit_seq_if.sv
// Request/response bundle for the multi-cycle EX-stage shifter.
// The master drives a request; the slave (the shifter) returns status and result.
interface shift_unit_seq_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] DataIn;
  logic [31:0] ShamtIn;
  logic [31:0] Result;
  logic        Busy;
  logic        Done;
  logic        OverRange;

  modport master (
    output Start, Op, DataIn, ShamtIn,
    input  Result, Busy, Done, OverRange
  );

  modport slave (
    input  Start, Op, DataIn, ShamtIn,
    output Result, Busy, Done, OverRange
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle SLL/SRL/SRA/ROTR shifter moving at most STEP bit positions per cycle.
// A Start/Busy/Done handshake lets the hazard unit stall EX while a shift runs.
module shift_unit_seq #(
  parameter int STEP = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  shift_unit_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [4:0] STEP_L  = 5'(STEP);

  // One partial shift of up to STEP positions; sign supplies the SRA fill.
  function automatic logic [31:0] shift_step(
    input logic [31:0] w,
    input logic [1:0]  op,
    input logic        sign,
    input logic [4:0]  s
  );
    logic [63:0] dbl;
    logic [31:0] keep_mask;
    logic [31:0] res;
    dbl       = {w, w} >> s;
    keep_mask = 32'hFFFF_FFFF >> s;
    case (op)
      OP_SLL:  res = w << s;
      OP_SRL:  res = w >> s;
      OP_SRA:  res = (w >> s) | (sign ? ~keep_mask : 32'h0000_0000);
      default: res = dbl[31:0];
    endcase
    return res;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  rem_q, rem_d;
  logic [1:0]  op_q, op_d;
  logic        sign_q, sign_d;
  logic [31:0] result_q, result_d;
  logic        over_q, over_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  step_s;
  logic [31:0] shifted_s;

  // Next-state, datapath and Moore output decode.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    op_d     = op_q;
    sign_d   = sign_q;
    result_d = result_q;
    over_d   = over_q;

    if (rem_q < STEP_L) begin
      step_s = rem_q;
    end else begin
      step_s = STEP_L;
    end
    shifted_s = shift_step(work_q, op_q, sign_q, step_s);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          work_d = bus.DataIn;
          rem_d  = bus.ShamtIn[4:0];
          op_d   = bus.Op;
          sign_d = bus.DataIn[31];
          over_d = |bus.ShamtIn[31:5];
          if (bus.ShamtIn[4:0] != 5'd0) begin
            state_d = ST_SHIFT;
          end else begin
            state_d  = ST_DONE;
            result_d = bus.DataIn;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = shifted_s;
        rem_d  = rem_q - step_s;
        if (rem_q == step_s) begin
          state_d  = ST_DONE;
          result_d = shifted_s;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      work_q   <= 32'h0000_0000;
      rem_q    <= 5'd0;
      op_q     <= 2'b00;
      sign_q   <= 1'b0;
      result_q <= 32'h0000_0000;
      over_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      over_q   <= over_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.Result    = result_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.OverRange = over_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: a cycle-count reference model checked every cycle,
// plus hand-computed results and latencies for each vector.
module tb_shift_unit_seq;
  localparam int STEP = 4;

  logic Clk = 1'b0;
  logic Rst;
  shift_unit_seq_if bus();

  shift_unit_seq #(.STEP(STEP)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int n);
    case (op)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   return $signed(d) >>> n;
      default: return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
    endcase
  endfunction

  function automatic int cycles_for(input logic [4:0] n);
    return (int'(n) + STEP - 1) / STEP;
  endfunction

  // Reference model: counts remaining busy cycles, applies the whole shift at once.
  int          m_left;
  logic        m_done;
  logic        m_over;
  logic [31:0] m_res;
  logic [31:0] m_pend;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_over <= 1'b0;
      m_res  <= 32'h0;
      m_pend <= 32'h0;
    end else if (m_left == 0) begin
      m_done <= 1'b0;
      if (bus.Start) begin
        m_over <= |bus.ShamtIn[31:5];
        if (bus.ShamtIn[4:0] == 5'd0) begin
          m_done <= 1'b1;
          m_res  <= bus.DataIn;
        end else begin
          m_left <= cycles_for(bus.ShamtIn[4:0]);
          m_pend <= ref_shift(bus.Op, bus.DataIn, int'(bus.ShamtIn[4:0]));
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= m_pend;
      end
    end
  end

  always @(negedge Clk) begin
    if (mon_en) begin
      chk("mon_busy",   32'(bus.Busy),      32'(m_left != 0));
      chk("mon_done",   32'(bus.Done),      32'(m_done));
      chk("mon_over",   32'(bus.OverRange), 32'(m_over));
      chk("mon_result", bus.Result,         m_res);
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] d,
                        input logic [31:0] sh, input logic [31:0] exp_res, input logic exp_over,
                        input int exp_lat, input int poke);
    int cyc;
    @(posedge Clk); #2;
    bus.Start = 1'b1; bus.Op = op; bus.DataIn = d; bus.ShamtIn = sh;
    @(posedge Clk); #2;
    bus.Start = 1'b0; bus.Op = ~op; bus.DataIn = ~d;
    cyc = 1;
    while (bus.Done !== 1'b1 && cyc < 40) begin
      if (cyc == poke) begin
        bus.Start = 1'b1; bus.DataIn = 32'hDEAD_BEEF; bus.ShamtIn = 32'd1;
      end else begin
        bus.Start = 1'b0;
      end
      @(posedge Clk); #2;
      cyc++;
    end
    bus.Start = 1'b0;
    chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({name, "_result"}, bus.Result, exp_res);
    chk({name, "_over"}, 32'(bus.OverRange), 32'(exp_over));
  endtask

  initial begin
    int cyc;
    bit seen;
    Rst = 1'b0;
    bus.Start = 1'b0; bus.Op = 2'b00; bus.DataIn = 32'h0; bus.ShamtIn = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_result", bus.Result, 32'h0);
    chk("rst_busy", 32'(bus.Busy), 32'h0);
    chk("rst_done", 32'(bus.Done), 32'h0);
    chk("rst_over", 32'(bus.OverRange), 32'h0);
    mon_en = 1'b1;
    #2 Rst = 1'b1;

    run_op("sll5",   2'b00, 32'h0000_0001, 32'd5,  32'h0000_0020, 1'b0, 3, 0);
    run_op("sra31",  2'b10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 9, 0);
    run_op("srl31",  2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 9, 0);
    run_op("rotr8",  2'b11, 32'h1234_5678, 32'd8,  32'h7812_3456, 1'b0, 3, 0);
    run_op("zero",   2'b10, 32'h8765_4321, 32'd0,  32'h8765_4321, 1'b0, 1, 0);
    run_op("over",   2'b00, 32'h0000_000F, 32'h24, 32'h0000_00F0, 1'b1, 2, 0);
    run_op("sra3",   2'b10, 32'h8000_0000, 32'd3,  32'hF000_0000, 1'b0, 2, 0);
    run_op("rotr13", 2'b11, 32'h0000_0001, 32'd13, 32'h0008_0000, 1'b0, 5, 0);
    run_op("ignore", 2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 9, 3);

    // Back-to-back: start a second operation in the DONE cycle of the first.
    run_op("b2b_a",  2'b01, 32'h0000_00F0, 32'd4,  32'h0000_000F, 1'b0, 2, 0);
    bus.Start = 1'b1; bus.Op = 2'b11; bus.DataIn = 32'h0000_0001; bus.ShamtIn = 32'd1;
    @(posedge Clk); #2;
    bus.Start = 1'b0;
    chk("b2b_busy", 32'(bus.Busy), 32'h1);
    cyc = 1;
    while (bus.Done !== 1'b1 && cyc < 40) begin
      @(posedge Clk); #2;
      cyc++;
    end
    chk("b2b_latency", 32'(cyc), 32'd2);
    chk("b2b_result", bus.Result, 32'h8000_0000);

    // Asynchronous reset in the middle of a long shift.
    @(posedge Clk); #2;
    bus.Start = 1'b1; bus.Op = 2'b01; bus.DataIn = 32'h8000_0000; bus.ShamtIn = 32'd31;
    @(posedge Clk); #2;
    bus.Start = 1'b0;
    repeat (3) @(posedge Clk);
    #4 Rst = 1'b0;
    #1;
    chk("arst_result", bus.Result, 32'h0);
    chk("arst_busy", 32'(bus.Busy), 32'h0);
    chk("arst_done", 32'(bus.Done), 32'h0);
    chk("arst_over", 32'(bus.OverRange), 32'h0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge Clk); #2;
      if (bus.Done === 1'b1) seen = 1'b1;
    end
    Rst = 1'b1;
    repeat (10) begin
      @(posedge Clk); #2;
      if (bus.Done === 1'b1) seen = 1'b1;
    end
    chk("arst_no_done", 32'(seen), 32'h0);
    run_op("post_rst", 2'b00, 32'h0000_0001, 32'd1, 32'h0000_0002, 1'b0, 2, 0);

    repeat (2) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
